// File: rtl/rr_arb_n.sv
// rr_arb_n: N-input round-robin arbiter for one switch output port.
// A grant is held for a whole packet. It ends when the owner drops req,
// when the owner asserts last, or when an optional hold limit expires
// while other inputs are waiting. The pointer always moves past the
// previous owner, so the owner has lowest priority at the next search.
module rr_arb_n #(
    parameter int N       = 4,
    parameter int IDW     = $clog2(N),
    parameter int MAXHOLD = 0
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   req,
    input  logic [N-1:0]   last,
    output logic [N-1:0]   ack,
    output logic           ack_valid,
    output logic [IDW-1:0] ack_id,
    output logic           busy
);

    localparam int HW = (MAXHOLD > 1) ? $clog2(MAXHOLD) : 1;
    localparam logic [HW-1:0] HOLD_TOP = HW'((MAXHOLD > 0) ? MAXHOLD - 1 : 0);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t         state_q, state_d;
    logic [N-1:0]   ack_q, ack_d;
    logic [IDW-1:0] id_q, id_d;
    logic [IDW-1:0] ptr_q, ptr_d;
    logic [HW-1:0]  hold_q, hold_d;
    logic           valid_q, valid_d;

    logic [IDW-1:0] after_owner;
    logic [IDW-1:0] start;
    logic           win_found;
    logic [IDW-1:0] win_id;
    logic           others;
    logic           hold_hit;
    logic           release_now;

    // Index just past the current owner, wrapping at N (N need not be 2^k).
    assign after_owner = (id_q == IDW'(N - 1)) ? '0 : id_q + IDW'(1);
    assign start       = (state_q == GRANT) ? after_owner : ptr_q;

    // First requester in rotating order start, start+1, ..., start+N-1.
    always_comb begin
        int idx;
        win_found = 1'b0;
        win_id    = '0;
        idx       = 0;
        for (int k = 0; k < N; k++) begin
            idx = int'(start) + k;
            if (idx >= N) idx = idx - N;
            if (!win_found && req[idx[IDW-1:0]]) begin
                win_found = 1'b1;
                win_id    = idx[IDW-1:0];
            end
        end
    end

    // Release: owner drops req, tail beat, or hold limit with others waiting.
    assign others      = |(req & ~ack_q);
    assign hold_hit    = (MAXHOLD > 0) && (hold_q == HOLD_TOP) && others;
    assign release_now = !req[id_q] || last[id_q] || hold_hit;

    // Next-state and next-output selection.
    always_comb begin
        state_d = state_q;
        ack_d   = ack_q;
        id_d    = id_q;
        ptr_d   = ptr_q;
        hold_d  = hold_q;
        valid_d = valid_q;
        case (state_q)
            IDLE: begin
                if (win_found) begin
                    state_d = GRANT;
                    ack_d   = N'(1) << win_id;
                    id_d    = win_id;
                    valid_d = 1'b1;
                    hold_d  = '0;
                end
            end
            GRANT: begin
                if (release_now) begin
                    ptr_d  = after_owner;
                    hold_d = '0;
                    if (win_found) begin
                        ack_d   = N'(1) << win_id;
                        id_d    = win_id;
                        valid_d = 1'b1;
                    end else begin
                        state_d = IDLE;
                        ack_d   = '0;
                        id_d    = '0;
                        valid_d = 1'b0;
                    end
                end else if ((MAXHOLD > 0) && (hold_q != HOLD_TOP)) begin
                    hold_d = hold_q + HW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                ack_d   = '0;
                id_d    = '0;
                valid_d = 1'b0;
            end
        endcase
    end

    // State and registered outputs; synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            ack_q   <= '0;
            id_q    <= '0;
            ptr_q   <= '0;
            hold_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ack_q   <= ack_d;
            id_q    <= id_d;
            ptr_q   <= ptr_d;
            hold_q  <= hold_d;
            valid_q <= valid_d;
        end
    end

    assign ack       = ack_q;
    assign ack_id    = id_q;
    assign ack_valid = valid_q;
    assign busy      = valid_q;

endmodule

// File: doc/rr_arb_n.md
Name: rr_arb_n

Overview:
- Parametrised N-input round-robin arbiter guarding one switch output port. It replaces the fixed 4-input arbiter.
- Grants one input at a time and holds that grant for a whole packet: until the owner drops req, or asserts last.
- Optional hold-limit forces release so a long packet cannot starve the other inputs.
- Rotating pointer always advances past the previous winner, including when a higher-priority input arrives mid-grant.

Parameters:
- N, 4, number of requesting input ports (2..16).
- IDW, $clog2(N), width of ack_id.
- MAXHOLD, 0, maximum consecutive grant cycles per owner while others wait; 0 = unlimited.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous reset, active-low (rst==0 resets on clk edge).
- req  in  N  per-input request; bit i = input i wants this output.
- last  in  N  per-input tail flag; meaningful only when req[i]==1 and ack[i]==1.
- ack  out  N  registered one-hot grant; all zero when idle.
- ack_valid  out  1  registered; 1 iff ack != 0.
- ack_id  out  IDW  registered index of the granted input; 0 when idle.
- busy  out  1  registered; 1 while state==GRANT.

Behaviour:
- Reset (rst==0 at clk edge): ack=0, ack_valid=0, ack_id=0, busy=0, ptr=0, hold_cnt=0, state=IDLE. Reset dominates all other events, including mid-grant; the next cycle after rst returns to 1 behaves as IDLE.
- State IDLE:
  - If req==0, stay in IDLE; outputs remain 0.
  - Otherwise select winner w = first i with req[i]==1, searching ptr, ptr+1, ..., ptr+N-1 (mod N).
  - Next edge: ack=onehot(w), ack_id=w, ack_valid=1, busy=1, hold_cnt=0, state=GRANT.
  - Latency from req seen to ack is 1 cycle.
- State GRANT, owner o. Release occurs in cycle t if any of:
  - (a) req[o]==0;
  - (b) req[o]==1 && last[o]==1, meaning the tail beat transfers in cycle t;
  - (c) MAXHOLD>0 && hold_cnt==MAXHOLD-1 && (req & ~onehot(o))!=0.
- No release: ack unchanged, hold_cnt increments, saturating at MAXHOLD-1.
- On release at cycle t:
  - ptr <= (o+1) mod N.
  - The next winner is searched from o+1 using req sampled at t. The owner is therefore lowest priority, and is excluded under (a) because its req is 0.
  - If a winner exists, ack switches directly to the new one-hot at t+1 with no idle bubble, hold_cnt=0, state stays GRANT.
  - If no winner exists, all outputs go to 0 at t+1 and state=IDLE.
- Under (b) with the owner the sole requester, the owner is re-granted at t+1 (new packet).
- A higher-priority req arriving mid-grant never preempts; only (a)/(b)/(c) end a grant.
- ack is always one-hot or zero and never changes except at a release or reset. ack_valid==|ack; busy==ack_valid.
- Under (c) with the owner still requesting, the owner keeps its req and competes again from lowest priority. The packet continues later; this is the upstream's concern, not the arbiter's.
- last is ignored for non-owner inputs.
- Width arithmetic: pointer and index wrap mod N; N not a power of 2 must wrap correctly (e.g. N=3: 2+1 -> 0).

Test Plan:
- Reset mid-grant: N=4, grant input 2 held, assert rst=0 for one cycle -> next cycle ack=0000, ack_id=0, busy=0. Then req=0110 -> ack=0010 (ptr reset to 0, input 1 wins).
- Round-robin rotation: req=1111 held, each owner pulses last for one cycle. Grants in order 0001, 0010, 0100, 1000, 0001, back-to-back with no zero cycle between.
- Packet hold: owner 0 granted, then req[3] rises mid-packet -> ack stays 0001. When last[0] is pulsed -> ack=1000 next cycle.
- Req drop with no other requester: owner 1, req goes 0010 -> 0000 -> ack=0000, busy=0 next cycle. Then req=0001 -> ack=0001 (ptr=2 wraps to 0).
- Hold limit: MAXHOLD=4, req[0] held with no last, req[2] asserted at cycle 1 of grant. ack=0001 for exactly 4 cycles, then 0100. Re-run with MAXHOLD=0 -> 0001 persists indefinitely.
- Non-power-of-2: N=3, req=111, last pulsed each grant -> ack_id sequence 0, 1, 2, 0. Single requester 2 with repeated last -> re-granted every packet, ack_id=2.
